// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered alu between two requesters
// Opcodes: 1 ADD, 2 SUB, 3 AND, 5 OR, 6 XOR, 7 SLT, 8 SLTU, 12 SLL, 13 SRL, 15 SRA; others illegal.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req_a0,
    input  logic [N-1:0] req_b0,
    input  logic [3:0]   req_op0,
    input  logic [N-1:0] req_a1,
    input  logic [N-1:0] req_b1,
    input  logic [3:0]   req_op1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_overflow,
    output logic         rsp_zero,
    output logic         rsp_equal,
    output logic         rsp_illegal,
    output logic         busy
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd12;
    localparam logic [3:0] OP_SRL  = 4'd13;
    localparam logic [3:0] OP_SRA  = 4'd15;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state;
    logic         rr_ptr;
    logic         gnt_id;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [3:0]   op_code;

    logic         grant;
    logic [N-1:0] addend;
    logic         carry_in;
    logic [N:0]   sum;
    logic         add_ovf;
    logic         shamt_big;
    logic [N-1:0] alu_result;
    logic         alu_overflow;
    logic         alu_illegal;

    assign busy = (state != IDLE);

    // The rr_ptr owner wins when it is asking; otherwise the other side may go.
    always_comb begin
        grant     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        req_ready = 2'b00;
        if (state == IDLE && req_valid[grant]) begin
            req_ready[grant] = 1'b1;
        end
    end

    // SUB and both compares share one adder computing a + ~b + 1.
    always_comb begin
        addend   = op_b;
        carry_in = 1'b0;
        if (op_code == OP_SUB || op_code == OP_SLT || op_code == OP_SLTU) begin
            addend   = ~op_b;
            carry_in = 1'b1;
        end
        sum          = {1'b0, op_a} + {1'b0, addend} + {{N{1'b0}}, carry_in};
        add_ovf      = (op_a[N-1] == addend[N-1]) && (sum[N-1] != op_a[N-1]);
        shamt_big    = |op_b[N-1:5];
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_illegal  = 1'b0;
        case (op_code)
            OP_ADD:  begin alu_result = sum[N-1:0]; alu_overflow = add_ovf; end
            OP_SUB:  begin alu_result = sum[N-1:0]; alu_overflow = add_ovf; end
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SLT:  alu_result = {{(N-1){1'b0}}, sum[N-1] ^ add_ovf};
            OP_SLTU: alu_result = {{(N-1){1'b0}}, ~sum[N]};
            OP_SLL:  alu_result = shamt_big ? '0 : op_a << op_b[4:0];
            OP_SRL:  alu_result = shamt_big ? '0 : op_a >> op_b[4:0];
            OP_SRA:  alu_result = shamt_big ? '0 : N'($signed(op_a) >>> op_b[4:0]);
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            gnt_id       <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            op_code      <= '0;
            rsp_valid    <= 2'b00;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_equal    <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        op_a    <= grant ? req_a1  : req_a0;
                        op_b    <= grant ? req_b1  : req_b0;
                        op_code <= grant ? req_op1 : req_op0;
                        gnt_id  <= grant;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result   <= alu_result;
                    rsp_overflow <= alu_overflow;
                    rsp_zero     <= (alu_result == '0);
                    rsp_equal    <= (op_a == op_b);
                    rsp_illegal  <= alu_illegal;
                    rsp_valid    <= gnt_id ? 2'b10 : 2'b01;
                    state        <= RESP;
                end
                RESP: begin
                    // Only the owning requester's ready bit completes the response.
                    if (rsp_ready[gnt_id]) begin
                        rsp_valid <= 2'b00;
                        rr_ptr    <= ~gnt_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural alu/arbiter model
module tb_alu_arbiter;

    localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd5, XOR_ = 4'd6;
    localparam logic [3:0] SLT = 4'd7, SLTU = 4'd8, SLL = 4'd12, SRL = 4'd13, SRA = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]  req_op0 = '0, req_op1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_zero, rsp_equal, rsp_illegal, busy;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_zero(rsp_zero), .rsp_equal(rsp_equal),
        .rsp_illegal(rsp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        id;
        logic [35:0] v;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb_q[$];
    int         grant_log[$];
    bit         outstanding = 1'b0;
    logic       out_id = 1'b0;
    int         acc_cyc = 0;
    logic       rr_m = 1'b0;
    logic [1:0] acc_flag = 2'b00;
    logic [1:0] auto_rep = 2'b00;
    int         done_cnt[2] = '{0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {illegal, overflow, zero, equal, result} from plain integer arithmetic.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] r;
        logic ov, ill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; ov = 1'b0; ill = 1'b0;
        case (op)
            ADD:  begin s = sa + sb; r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            SUB:  begin s = sa - sb; r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            SLTU: r = (a < b) ? 32'd1 : 32'd0;
            SLL:  r = (b >= 32) ? 32'd0 : a << b;
            SRL:  r = (b >= 32) ? 32'd0 : a >> b;
            SRA:  r = (b >= 32) ? 32'd0 : 32'(sa >>> b);
            default: ill = 1'b1;
        endcase
        return {ill, ov, (r == 32'd0), (a == b), r};
    endfunction

    // Acceptor: checks arbitration each cycle and pushes expectations on accept.
    initial begin
        logic g;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (outstanding) begin
                    check("req_ready_busy", req_ready, 2'b00);
                end else if (req_valid != 2'b00) begin
                    g = req_valid[rr_m] ? rr_m : ~rr_m;
                    check("grant", req_ready, g ? 2'b10 : 2'b01);
                    if (req_ready == (g ? 2'b10 : 2'b01)) begin
                        sb_q.push_back('{id: g, v: g ? ref_alu(req_op1, req_a1, req_b1)
                                                     : ref_alu(req_op0, req_a0, req_b0)});
                        outstanding = 1'b1;
                        out_id      = g;
                        acc_cyc     = cyc;
                        acc_flag[g] = 1'b1;
                        grant_log.push_back(int'(g));
                    end
                end else begin
                    check("req_ready_idle", req_ready, 2'b00);
                end
            end
        end
    end

    // Monitor: compares response against the scoreboard and tracks handshakes.
    initial begin
        logic [1:0] exp_valid;
        exp_t f;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                exp_valid = (outstanding && cyc >= acc_cyc + 2) ? (out_id ? 2'b10 : 2'b01) : 2'b00;
                check("rsp_valid", rsp_valid, exp_valid);
                check("busy", busy, outstanding && (cyc > acc_cyc));
                if (exp_valid != 2'b00 && rsp_valid == exp_valid) begin
                    check("sb_nonempty", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        f = sb_q[0];
                        check("rsp_id", out_id, f.id);
                        check("rsp_fields", {rsp_illegal, rsp_overflow, rsp_zero, rsp_equal, rsp_result}, f.v);
                        if (rsp_ready[out_id]) begin
                            void'(sb_q.pop_front());
                            outstanding = 1'b0;
                            rr_m        = ~out_id;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i] = 1'b0;
                done_cnt[i]++;
                if (!auto_rep[i]) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
        else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_acc(input int i, input int start);
        int n = 0;
        while (done_cnt[i] == start && n < 40) begin cycle(); n++; end
        check("accept_timeout", done_cnt[i] != start, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((outstanding || req_valid != 2'b00 || sb_q.size() != 0) && n < 200) begin cycle(); n++; end
        check("idle_timeout", outstanding || req_valid != 2'b00 || sb_q.size() != 0, 0);
    endtask

    task automatic do_op(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int start = done_cnt[i];
        set_req(i, op, a, b);
        wait_acc(i, start);
        wait_idle();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 40));
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int start, s1, n;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_result", rsp_result, 32'd0);
        check("reset_flags", {rsp_overflow, rsp_zero, rsp_equal, rsp_illegal}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-EXEC abandons the op and returns rr_ptr to 0.
        do_op(0, ADD, 32'd1, 32'd2);
        start = done_cnt[0];
        set_req(0, ADD, 32'd5, 32'd7);
        wait_acc(0, start);
        rst_n = 1'b0;
        req_valid = 2'b00;
        sb_q.delete();
        outstanding = 1'b0;
        rr_m = 1'b0;
        #1;
        check("t1_rsp_valid", rsp_valid, 2'b00);
        check("t1_busy", busy, 1'b0);
        check("t1_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle();

        // Contention: both valid every cycle, grants must alternate from requester 0.
        grant_log.delete();
        auto_rep = 2'b11;
        set_req(0, SUB, 32'd3, 32'd3);
        set_req(1, XOR_, 32'hF0, 32'h0F);
        n = 0;
        while (grant_log.size() < 3 && n < 40) begin cycle(); n++; end
        auto_rep = 2'b00;
        check("t3_grant_count", grant_log.size() >= 3, 1);
        if (grant_log.size() >= 3) begin
            check("t3_grant0", grant_log[0], 0);
            check("t3_grant1", grant_log[1], 1);
            check("t3_grant2", grant_log[2], 0);
        end
        wait_idle();

        do_op(0, ADD, 32'h7FFF_FFFF, 32'd1);

        // Backpressure on requester 0 with requester 1 pending.
        rsp_ready = 2'b10;
        start = done_cnt[0];
        set_req(0, OR_, 32'h1234_0000, 32'h0000_5678);
        wait_acc(0, start);
        s1 = done_cnt[1];
        set_req(1, AND_, 32'hFF00_FF00, 32'h0FF0_0FF0);
        repeat (6) cycle();
        rsp_ready = 2'b11;
        cycle();
        #1;
        check("t4_req1_accept", req_ready, 2'b10);
        wait_acc(1, s1);
        wait_idle();

        do_op(1, 4'd4, 32'd9, 32'd9);
        do_op(0, SLL, 32'd1, 32'd32);
        do_op(1, SLTU, 32'd1, 32'hFFFF_FFFF);
        do_op(0, SLT, 32'hFFFF_FFFF, 32'd1);
        do_op(1, SRA, 32'h8000_0000, 32'd4);
        do_op(0, SRA, 32'h8000_0000, 32'd40);
        do_op(1, SUB, 32'h8000_0000, 32'd1);

        // Ready on the wrong bit must not complete requester 1's response.
        rsp_ready = 2'b01;
        start = done_cnt[1];
        set_req(1, ADD, 32'd10, 32'd20);
        wait_acc(1, start);
        repeat (5) cycle();
        rsp_ready = 2'b11;
        wait_idle();

        repeat (600) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
            end
            rsp_ready = 2'($urandom_range(0, 3));
        end
        rsp_ready = 2'b11;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
